// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box, word helpers, round constants and
// the key-schedule state encoding.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Round constant for the step that produces round `round` (1..10); 0 otherwise.
    function automatic logic [31:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h0};
    endfunction

endpackage

// File: rtl/aes_key_unstep.sv
// Combinational inverse of one AES-128 key-expansion step: round key r -> round key r-1.
module aes_key_unstep
    import aes_pkg::*;
(
    input  logic [127:0] key,
    input  logic [3:0]   round,
    output logic [127:0] prev_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;

    assign {w0, w1, w2, w3} = key;

    // Undo the chained XORs first; the recovered w3 feeds the S-box path.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign p0 = w0 ^ sub_word(rot_word(p3)) ^ rcon(round);

    assign prev_key = {p0, p1, p2, p3};

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Reverse AES-128 key schedule: emits round keys 10..0 over a valid/ready handshake.
// Optional LAST_KEY_DERIVE_EN: IN_KEY is the cipher key and round 10 is derived first.
//
// state | meaning
// IDLE  | waiting for START
// FWD   | deriving the round-10 key from the cipher key, one step per cycle
// EMIT  | presenting key_reg/round_reg, stepping backwards on each transfer
module aes_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         START,
    input  logic [127:0] IN_KEY,
    input  logic         KEY_READY,
    output logic         KEY_VALID,
    output logic [127:0] OUT_KEY,
    output logic [3:0]   OUT_ROUND,
    output logic         BUSY,
    output logic         DONE
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t       state, state_nxt;
    logic [127:0] key_reg, key_nxt;
    logic [3:0]   round_reg, round_nxt;
    logic         done_reg, done_nxt;
    logic [127:0] prev_key;

    aes_key_unstep u_unstep (
        .key      (key_reg),
        .round    (round_reg),
        .prev_key (prev_key)
    );

`ifdef LAST_KEY_DERIVE_EN
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] next_key;

    // In FWD, round_reg counts the forward step being applied (1..10).
    assign f0 = key_reg[127:96] ^ sub_word(rot_word(key_reg[31:0])) ^ rcon(round_reg);
    assign f1 = key_reg[95:64] ^ f0;
    assign f2 = key_reg[63:32] ^ f1;
    assign f3 = key_reg[31:0]  ^ f2;
    assign next_key = {f0, f1, f2, f3};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_reg   <= '0;
            round_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state     <= state_nxt;
            key_reg   <= key_nxt;
            round_reg <= round_nxt;
            done_reg  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        key_nxt   = key_reg;
        round_nxt = round_reg;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    key_nxt = IN_KEY;
`ifdef LAST_KEY_DERIVE_EN
                    round_nxt = 4'd1;
                    state_nxt = FWD;
`else
                    round_nxt = LAST_ROUND;
                    state_nxt = EMIT;
`endif
                end
            end
            FWD: begin
`ifdef LAST_KEY_DERIVE_EN
                key_nxt = next_key;
                if (round_reg == LAST_ROUND) begin
                    state_nxt = EMIT;
                end else begin
                    round_nxt = round_reg + 4'd1;
                end
`else
                state_nxt = IDLE;
`endif
            end
            EMIT: begin
                if (KEY_READY) begin
                    if (round_reg != 4'd0) begin
                        key_nxt   = prev_key;
                        round_nxt = round_reg - 4'd1;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on KEY_READY.
    assign KEY_VALID = (state == EMIT);
    assign OUT_KEY   = KEY_VALID ? key_reg : '0;
    assign OUT_ROUND = KEY_VALID ? round_reg : '0;
    assign BUSY      = (state != IDLE);
    assign DONE      = done_reg;

endmodule
